commit_trace_serializer: RTL
============================

Name: commit_trace_serializer

Overview:
- Sits between the DUT core's retirement ports and the co-simulation commit checker.
- Captures up to COMMITS retirements per cycle into an ordered queue: PC, instruction, integer write-back.
- Replays them to the checker as an in-order stream, one retirement per accepted handshake.
- Absorbs bursts so the checker sees strictly program-ordered commits.

Parameters:
COMMITS, 2, retirement lanes per cycle; lane 0 is oldest
DEPTH, 8, queue entries; power of two, >= 2*COMMITS
XLEN, 64, PC and write-data width

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  COMMITS  per-lane retirement valid
in_pc  input  COMMITS*XLEN  lane i at bits [i*XLEN +: XLEN]
in_insn  input  COMMITS*32  raw instruction per lane
in_wen  input  COMMITS  lane writes an integer register
in_waddr  input  COMMITS*5  destination register index
in_wdata  input  COMMITS*XLEN  write-back data
in_ready  output  1  queue can take a full COMMITS-wide group this cycle
out_valid  output  1  head entry available
out_ready  input  1  checker consumes head
out_pc  output  XLEN  head PC
out_insn  output  32  head instruction
out_wen  output  1  head write enable
out_waddr  output  5  head register index; 0 when out_wen=0
out_wdata  output  XLEN  head write data; 0 when out_wen=0
occupancy  output  log2(DEPTH)+1  current entry count
overflow  output  1  sticky: a retirement group was dropped

Behaviour:
- Reset asserted (reset=0), immediate effect: head/tail pointers=0, occupancy=0, out_valid=0, overflow=0, in_ready=1.
- Reset clears all payload outputs to 0. Storage contents are don't-care.
- Reset mid-operation discards all queued entries. No output handshake may complete while reset=0.
- in_ready = (DEPTH - occupancy) >= COMMITS, computed from registered state only. It never depends on in_valid or out_ready.
- Enqueue when |in_valid && in_ready.
- Valid lanes are compacted in ascending lane order into consecutive slots starting at the tail. Invalid lanes consume no slot; gaps such as in_valid=2'b10 are legal.
- Tail advances by popcount(in_valid) in the same cycle.
- Lanes with in_wen=0 store waddr=0 and wdata=0, regardless of bus contents.
- waddr=0 with in_wen=1 is stored as given; the checker judges it.
- Dequeue when out_valid && out_ready; head advances by 1.
- out_valid = (occupancy != 0).
- Head payload is driven directly from storage at the head pointer. It is stable while out_valid && !out_ready.
- No bypass: an entry enqueued at edge N is first visible on the outputs after edge N, i.e. minimum latency is 1 cycle.
- Simultaneous enqueue and dequeue is legal. occupancy_next = occupancy + popcount(accepted in_valid) - dequeue.
- A dequeue in the same cycle does not raise in_ready; capacity is judged before the edge.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. A group may straddle the wrap, e.g. tail=7 with two lanes writes slots 7 then 0.
- Overflow: |in_valid && !in_ready drops the entire group; no partial enqueue.
  - overflow is set at that edge and stays 1 until reset.
  - Queue state is otherwise unaffected.
  - The DUT is never back-pressured, so this is an error flag only.
- Order guarantee: out stream = retirements in cycle order, lane order within a cycle.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, occupancy=0, overflow=0 across 10 cycles.
- Single lane: in_valid=01, pc=0x80000000, insn=0x00000093, wen=1, waddr=1, wdata=0; out_ready=1 -> one cycle later out_valid=1 with same payload; occupancy returns to 0 the cycle after.
- Dual-lane burst: 4 cycles of in_valid=11, PCs 0x80000000..0x8000001C step 4, out_ready=0 -> occupancy=8, in_ready=0.
  - Then out_ready=1 -> PCs emerge strictly ascending, one per cycle.
- Gapped lanes and wrap: pre-advance pointers to 7, send in_valid=10 then in_valid=11 -> slots 7,0,1 used; output order lane1, lane0, lane1; wen=0 lanes show waddr=0, wdata=0.
- Overflow: fill to occupancy=7, send in_valid=01 -> in_ready=0, group dropped, overflow=1 and stays set after draining; occupancy still 7.
- Reset mid-stream: occupancy=5 and out_ready toggling, pull reset low between edges -> out_valid and occupancy drop to 0 immediately, without waiting for a clock edge; no further handshakes; after release, new commits start at slot 0.

Source files
------------

// File: rtl/commit_trace_serializer.sv
// commit_trace_serializer
//   Collects up to COMMITS retirements per cycle from the core and replays
//   them one at a time, in program order, to the co-simulation commit
//   checker. Lane 0 is the oldest retirement within a cycle.
//
// Ports
//   clock      : sole clock, rising edge
//   reset      : asynchronous active-low reset
//   in_valid   : per-lane retirement valid
//   in_pc      : per-lane PC, lane i at [i*XLEN +: XLEN]
//   in_insn    : per-lane raw instruction, lane i at [i*32 +: 32]
//   in_wen     : per-lane integer write-back enable
//   in_waddr   : per-lane destination register, lane i at [i*5 +: 5]
//   in_wdata   : per-lane write-back data, lane i at [i*XLEN +: XLEN]
//   in_ready   : a full COMMITS-wide group fits this cycle
//   out_valid  : head entry available
//   out_ready  : checker consumes the head entry
//   out_pc/out_insn/out_wen/out_waddr/out_wdata : head entry payload
//   occupancy  : current number of queued entries
//   overflow   : sticky, set when a retirement group was dropped
module commit_trace_serializer #(
    parameter int COMMITS = 2,
    parameter int DEPTH   = 8,
    parameter int XLEN    = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [COMMITS-1:0]        in_valid,
    input  logic [COMMITS*XLEN-1:0]   in_pc,
    input  logic [COMMITS*32-1:0]     in_insn,
    input  logic [COMMITS-1:0]        in_wen,
    input  logic [COMMITS*5-1:0]      in_waddr,
    input  logic [COMMITS*XLEN-1:0]   in_wdata,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [31:0]               out_insn,
    output logic                      out_wen,
    output logic [4:0]                out_waddr,
    output logic [XLEN-1:0]           out_wdata,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int CNT_W = $clog2(COMMITS + 1);

    logic [XLEN-1:0]  r_mem_pc    [DEPTH];
    logic [31:0]      r_mem_insn  [DEPTH];
    logic             r_mem_wen   [DEPTH];
    logic [4:0]       r_mem_waddr [DEPTH];
    logic [XLEN-1:0]  r_mem_wdata [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;
    logic             r_overflow;

    logic [PTR_W-1:0] w_slot [COMMITS];
    logic [CNT_W-1:0] w_cnt;
    logic [OCC_W-1:0] w_free;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_enq;
    logic             w_deq;
    logic             w_drop;
    logic [OCC_W-1:0] w_occ_add;
    logic [OCC_W-1:0] w_occ_sub;

    // Compaction: each valid lane lands at tail + (number of valid older lanes),
    // so gaps in in_valid consume no slot. Pointer arithmetic wraps naturally.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < COMMITS; i++) begin
            w_slot[i] = r_tail + PTR_W'(w_cnt);
            if (in_valid[i]) begin
                w_cnt = w_cnt + CNT_W'(1);
            end
        end
    end

    // Capacity is judged from registered occupancy only, so a dequeue in the
    // same cycle never opens room for an incoming group.
    assign w_free      = OCC_W'(DEPTH) - r_occ;
    assign w_in_ready  = (w_free >= OCC_W'(COMMITS));
    assign w_out_valid = (r_occ != '0);
    assign w_enq       = (|in_valid) && w_in_ready;
    assign w_drop      = (|in_valid) && !w_in_ready;
    assign w_deq       = w_out_valid && out_ready;
    assign w_occ_add   = w_enq ? OCC_W'(w_cnt) : '0;
    assign w_occ_sub   = {{(OCC_W-1){1'b0}}, w_deq};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(w_cnt);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_occ <= r_occ + w_occ_add - w_occ_sub;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset; an empty queue masks it at the outputs.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            for (int i = 0; i < COMMITS; i++) begin
                if (in_valid[i]) begin
                    r_mem_pc[w_slot[i]]    <= in_pc[i*XLEN +: XLEN];
                    r_mem_insn[w_slot[i]]  <= in_insn[i*32 +: 32];
                    r_mem_wen[w_slot[i]]   <= in_wen[i];
                    r_mem_waddr[w_slot[i]] <= in_wen[i] ? in_waddr[i*5 +: 5] : 5'd0;
                    r_mem_wdata[w_slot[i]] <= in_wen[i] ? in_wdata[i*XLEN +: XLEN] : '0;
                end
            end
        end
    end

    // Head payload comes straight from storage; gating with out_valid makes
    // the outputs read zero while empty, including immediately on reset.
    assign out_pc    = w_out_valid ? r_mem_pc[r_head]    : '0;
    assign out_insn  = w_out_valid ? r_mem_insn[r_head]  : 32'd0;
    assign out_wen   = w_out_valid ? r_mem_wen[r_head]   : 1'b0;
    assign out_waddr = w_out_valid ? r_mem_waddr[r_head] : 5'd0;
    assign out_wdata = w_out_valid ? r_mem_wdata[r_head] : '0;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign occupancy = r_occ;
    assign overflow  = r_overflow;

endmodule
